// File: rtl/mem_bus_master.sv
// CPU-side memory bus master: runs one IDLE/ADDR/T3A/T3B/DONE cycle per accepted request.
// Define MEM_BUS_MASTER_ROM_WRITE_TRAP_EN to trap ROM writes with an err pulse instead of a bus cycle.
module mem_bus_master (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       busy,
  output logic       err,
  output logic [7:0] ar,
  output logic       ce,
  output logic       we,
  output logic       t3,
  inout  wire  [7:0] bus
);

  typedef enum logic [2:0] {IDLE, ADDR, T3A, T3B, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic       wr_reg;
  logic       rom_wr;
  logic       bus_oe;

  // Handshake: req (with wr/addr/wdata) is taken only in IDLE; ack pulses for one
  // cycle when the access ends, and any req seen while busy is dropped, not queued.
`ifdef MEM_BUS_MASTER_ROM_WRITE_TRAP_EN
  logic trap_reg;

  assign rom_wr = wr & ~addr[7];
  assign err    = (state == DONE) && trap_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_reg <= 1'b0;
    end else if (state == IDLE && req) begin
      trap_reg <= rom_wr;
    end
  end
`else
  assign rom_wr = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr_reg  <= addr;
        wdata_reg <= wdata;
        wr_reg    <= wr;
      end
      // The memory drives bus through T3B; capture on the edge that ends it.
      if (state == T3B && !wr_reg) begin
        rdata <= bus;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ce        = 1'b0;
    we        = 1'b0;
    t3        = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = rom_wr ? DONE : ADDR;
        end
      end
      ADDR: begin
        ce        = 1'b1;
        we        = wr_reg;
        state_nxt = T3A;
      end
      T3A: begin
        ce        = 1'b1;
        we        = wr_reg;
        t3        = 1'b1;
        state_nxt = T3B;
      end
      T3B: begin
        ce        = 1'b1;
        we        = wr_reg;
        t3        = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ar     = addr_reg;
  assign busy   = (state != IDLE);
  assign bus_oe = ((state == T3A) || (state == T3B)) && wr_reg;
  assign bus    = bus_oe ? wdata_reg : 8'hzz;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a RAM/ROM model on the shared bus.
// Expected read data is queued when a read is issued and popped at its ack.
module tb_mem_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  wire  [7:0] rdata;
  wire        ack, busy, err, ce, we, t3;
  wire  [7:0] ar;
  wire  [7:0] bus;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rdata = 8'h00;
  logic [7:0] ram [128];

  mem_bus_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .busy  (busy),
    .err   (err),
    .ar    (ar),
    .ce    (ce),
    .we    (we),
    .t3    (t3),
    .bus   (bus)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA7 : (a ^ 8'h5A);
  endfunction

  assign bus = (ce && !we && t3) ? (ar[7] ? ram[ar[6:0]] : rom_val(ar)) : 8'hzz;

  always @(posedge clk) begin
    if (ce && we && t3 && ar[7]) ram[ar[6:0]] <= bus;
  end

  // ---------------- driver: one complete access ----------------
  task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input bit trap_exp);
    int         lat;
    int         t3_cnt;
    int         ce_cnt;
    bit         seen;
    logic [7:0] e;
    int         exp_lat;
    exp_lat = trap_exp ? 1 : 4;
    seen = 0; lat = 0; t3_cnt = 0; ce_cnt = 0;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (t3) t3_cnt++;
      if (ce) ce_cnt++;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++; $display("FAIL busy a=%0h n=%0d: got %b want 1", a, n, busy);
      end
      if (!w && we !== 1'b0) begin
        miscompares++; $display("FAIL we_read a=%0h n=%0d: got %b want 0", a, n, we);
      end
      if (w && ce && we !== 1'b1) begin
        miscompares++; $display("FAIL we_write a=%0h n=%0d: got %b want 1", a, n, we);
      end
      if (n <= 4 && ar !== a) begin
        miscompares++; $display("FAIL ar n=%0d: got %0h want %0h", n, ar, a);
      end
      if (w && t3 && bus !== d) begin
        miscompares++; $display("FAIL bus_wdata a=%0h n=%0d: got %0h want %0h", a, n, bus, d);
      end
      if (w && !t3 && bus === d) begin
        miscompares++; $display("FAIL bus_idle_drive a=%0h n=%0d: got %0h want not %0h", a, n, bus, d);
      end
      if (!w && t3 && !a[7] && bus !== rom_val(a)) begin
        miscompares++; $display("FAIL bus_rom a=%0h n=%0d: got %0h want %0h", a, n, bus, rom_val(a));
      end
      if (ack === 1'b1) begin
        seen = 1; lat = n;
        if (err !== trap_exp) begin
          miscompares++; $display("FAIL err_ack a=%0h: got %b want %b", a, err, trap_exp);
        end
        if (!w) begin
          e = exp_q.pop_front();
          if (rdata !== e) begin
            miscompares++; $display("FAIL rdata a=%0h: got %0h want %0h", a, rdata, e);
          end
          model_rdata = e;
        end else if (rdata !== model_rdata) begin
          miscompares++; $display("FAIL rdata_wr a=%0h: got %0h want %0h", a, rdata, model_rdata);
        end
      end else begin
        if (err !== 1'b0) begin
          miscompares++; $display("FAIL err_idle a=%0h n=%0d: got %b want 0", a, n, err);
        end
        if (rdata !== model_rdata) begin
          miscompares++; $display("FAIL rdata_hold a=%0h n=%0d: got %0h want %0h", a, n, rdata, model_rdata);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL ack_timeout a=%0h: got none want ack", a);
      if (!w && exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (lat != exp_lat) begin
      miscompares++; $display("FAIL latency a=%0h: got %0d want %0d", a, lat, exp_lat);
    end
    if (t3_cnt != (trap_exp ? 0 : 2)) begin
      miscompares++; $display("FAIL t3_cycles a=%0h: got %0d want %0d", a, t3_cnt, trap_exp ? 0 : 2);
    end
    if (ce_cnt != (trap_exp ? 0 : 3)) begin
      miscompares++; $display("FAIL ce_cycles a=%0h: got %0d want %0d", a, ce_cnt, trap_exp ? 0 : 3);
    end
    @(negedge clk);
    vectors++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ack_width a=%0h: got ack=%b busy=%b want 0 0", a, ack, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ar, ce, we, t3, ack, err, busy, rdata} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_values: got ar=%0h ce=%b we=%b t3=%b ack=%b err=%b busy=%b rdata=%0h want all 0",
               ar, ce, we, t3, ack, err, busy, rdata);
    end
    rst_n = 1'b1;
    model_rdata = 8'h00;
  endtask

  task automatic test_ram_write_read();
    do_access(1'b1, 8'h85, 8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    do_access(1'b0, 8'h85, 8'hC3, 1'b0);
  endtask

  task automatic test_rom_read();
    exp_q.push_back(8'hA7);
    do_access(1'b0, 8'h10, 8'hFF, 1'b0);
  endtask

  task automatic test_rom_write();
`ifdef MEM_BUS_MASTER_ROM_WRITE_TRAP_EN
    do_access(1'b1, 8'h10, 8'hFF, 1'b1);
`else
    do_access(1'b1, 8'h10, 8'hFF, 1'b0);
`endif
    exp_q.push_back(8'hA7);
    do_access(1'b0, 8'h10, 8'h00, 1'b0);
  endtask

  task automatic test_req_held();
    logic [7:0] e;
    int         t3_cnt;
    bit         exp_ack;
    t3_cnt = 0;
    repeat (3) exp_q.push_back(8'h3C);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 8'h85; wdata = 8'h00;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 14) req = 1'b0;
      if (t3) t3_cnt++;
      exp_ack = (n == 4) || (n == 9) || (n == 14);
      vectors++;
      if (ack !== exp_ack) begin
        miscompares++; $display("FAIL held_ack n=%0d: got %b want %b", n, ack, exp_ack);
      end
      if (busy !== !((n == 5) || (n == 10) || (n == 15))) begin
        miscompares++; $display("FAIL held_busy n=%0d: got %b", n, busy);
      end
      if (exp_ack && ack === 1'b1) begin
        e = exp_q.pop_front();
        if (rdata !== e) begin
          miscompares++; $display("FAIL held_rdata n=%0d: got %0h want %0h", n, rdata, e);
        end
        model_rdata = e;
      end
    end
    vectors++;
    if (t3_cnt != 6) begin
      miscompares++; $display("FAIL held_t3_cycles: got %0d want 6", t3_cnt);
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 8'h90; wdata = 8'h5A;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (t3 !== 1'b1) begin
      miscompares++; $display("FAIL mid_in_t3a: got t3=%b want 1", t3);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ar, ce, we, t3, ack, err, busy, rdata} !== 22'h0 || bus === 8'h5A) begin
      miscompares++;
      $display("FAIL mid_reset_values: got ar=%0h ce=%b we=%b t3=%b ack=%b err=%b busy=%b rdata=%0h bus=%0h want all 0 bus=Z",
               ar, ce, we, t3, ack, err, busy, rdata, bus);
    end
    model_rdata = 8'h00;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      vectors++;
      if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL mid_no_ack n=%0d: got ack=%b err=%b busy=%b want 0 0 0", n, ack, err, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 8'h80, 8'h11, 1'b0);
    do_access(1'b1, 8'h81, 8'h22, 1'b0);
    exp_q.push_back(8'h11);
    do_access(1'b0, 8'h80, 8'hEE, 1'b0);
    exp_q.push_back(8'h22);
    do_access(1'b0, 8'h81, 8'hDD, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      a = 8'h80 | 8'($urandom_range(32, 127));
      d = 8'($urandom_range(1, 254));
      do_access(1'b1, a, d, 1'b0);
      exp_q.push_back(d);
      do_access(1'b0, a, 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ram_write_read();
    test_rom_read();
    test_rom_write();
    test_req_held();
    test_reset_mid();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset, and SHALL name them clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 req  input  1  access request from the CPU core, sampled only in IDLE.
REQ-005 wr  input  1  access type: 1 = write, 0 = read; captured with req.
REQ-006 addr  input  8  access address, captured with req; addr[7]=1 selects RAM, addr[7]=0 selects ROM.
REQ-007 wdata  input  8  write data, captured with req.
REQ-008 rdata  output  8  read data; valid while ack=1 on a read.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  error pulse, coincident with ack.
REQ-012 ar  output  8  memory address bus to the memory block.
REQ-013 ce  output  1  memory chip enable.
REQ-014 we  output  1  memory write enable.
REQ-015 t3  output  1  memory access strobe.
REQ-016 bus  inout  8  shared data bus; the block drives it only during write strobes and holds it at Z otherwise.

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, T3A, T3B and DONE, with one state per clock cycle.
REQ-018 In IDLE with req=1, the block SHALL capture addr, wr and wdata into internal registers and go to ADDR; in IDLE with req=0 it SHALL stay in IDLE.
REQ-019 In ADDR, the block SHALL drive ar=addr_reg, ce=1, we=wr_reg and t3=0, and go to T3A.
REQ-020 In T3A and T3B, the block SHALL hold ar, ce and we unchanged and drive t3=1.
REQ-021 On a write, the block SHALL drive bus=wdata_reg in T3A and T3B only; the resulting double RAM write of the same data is permitted.
REQ-022 On a read, the block SHALL keep bus at Z and load rdata from bus on the clock edge that ends T3B.
REQ-023 In DONE, the block SHALL drive ce=0, we=0, t3=0 and ack=1, hold ar, and go to IDLE on the next edge.
REQ-024 Latency: with req sampled at edge k, ack SHALL be high in cycle k+4, and the next req SHALL be accepted no earlier than edge k+5.
REQ-025 The block SHALL ignore req while busy=1; requests are neither queued nor counted.
REQ-026 rdata SHALL hold its value until the next read completes; a write SHALL NOT modify rdata.
REQ-027 Outside ADDR, T3A and T3B, ce, we and t3 SHALL be 0.
REQ-028 The bus output enable SHALL be 1 only when the state is T3A or T3B and wr_reg=1.

Reset
REQ-029 On rst_n=0 at a clock edge, the block SHALL enter IDLE regardless of current state.
REQ-030 Reset values SHALL be: ar=0, ce=0, we=0, t3=0, ack=0, err=0, busy=0, rdata=0, bus=Z.
REQ-031 A reset asserted mid-transaction SHALL abort it with no ack and no err.

Configuration
REQ-032 The macro MEM_BUS_MASTER_ROM_WRITE_TRAP_EN SHALL select the ROM-write behaviour.
REQ-033 When MEM_BUS_MASTER_ROM_WRITE_TRAP_EN is defined, a write request with addr[7]=0 SHALL go from IDLE directly to DONE, assert no ce, we or t3, leave bus at Z, and give ack=1 with err=1 in DONE.
REQ-034 When MEM_BUS_MASTER_ROM_WRITE_TRAP_EN is undefined, ROM writes SHALL run the normal write sequence and err SHALL be tied to 0.

Verification
REQ-035 The bench SHALL cover a RAM write then read: write addr=0x85 data=0x3C, then read 0x85 -> ack in cycle k+4 each time, rdata=0x3C, t3 high for exactly 2 cycles per access.
REQ-036 The bench SHALL cover a ROM read: ROM content[0x10]=0xA7, read 0x10 -> rdata=0xA7, bus never driven by the master, we=0 throughout.
REQ-037 The bench SHALL cover a ROM write with MEM_BUS_MASTER_ROM_WRITE_TRAP_EN defined: write 0x10 data 0xFF -> ack=1 and err=1 in cycle k+1, ce never high, ROM[0x10] unchanged.
REQ-038 The bench SHALL cover req held high continuously: exactly one access per 5 cycles, ack pulses 5 cycles apart, each ack 1 cycle wide.
REQ-039 The bench SHALL cover reset in T3A of a write to 0x90: rst_n=0 for one edge -> all outputs at reset values and bus=Z next cycle, no ack, busy=0.
REQ-040 The bench SHALL cover back-to-back reads of 0x80 (0x11) and 0x81 (0x22): rdata=0x11 then 0x22, and the first value is held between the two acks.
